stream_downsize: RTL

//  Wide-to-narrow AXI-Stream-style converter, the transmit-side counterpart of the stream upsizer.
//  - Accepts one wide beat of T_DATA_RATIO lanes with a per-lane keep mask.
//  - Replays the kept lanes as narrow beats, in ascending lane order.
//  - Preserves packet boundaries via last.
//  - Sits between the wide datapath and a T_DATA_WIDTH-bit sink.

---
 rtl/stream_downsize_pkg.sv | 28 ++
 rtl/stream_lane_pick.sv | 27 ++
 rtl/stream_downsize.sv | 103 ++++++++++
 3 files changed

// File: rtl/stream_downsize_pkg.sv
// Shared types and lane-selection helpers for the stream downsizer.
// Masks are handled at a fixed maximum width so the helpers can be reused at any
// lane ratio up to MAX_RATIO; callers zero-extend and truncate as needed.
package stream_downsize_pkg;

    typedef enum logic {IDLE, SEND} state_e;

    localparam int unsigned MAX_RATIO = 64;
    localparam int unsigned MAX_IDX_W = 6;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [MAX_IDX_W-1:0] first_set(input logic [MAX_RATIO-1:0] mask);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = MAX_RATIO - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = MAX_IDX_W'(i);
            end
        end
        return idx;
    endfunction

    // True when exactly one bit of the mask is set.
    function automatic logic is_onehot(input logic [MAX_RATIO-1:0] mask);
        return (mask != '0) && ((mask & (mask - MAX_RATIO'(1))) == '0);
    endfunction

endpackage

// File: rtl/stream_lane_pick.sv
// Combinational lane selector: picks the lowest still-pending lane of the held
// wide beat and reports whether it is the only one left.
module stream_lane_pick
    import stream_downsize_pkg::*;
#(
    parameter int unsigned T_DATA_WIDTH = 1,
    parameter int unsigned T_DATA_RATIO = 2,
    localparam int unsigned IDX_W       = $clog2(T_DATA_RATIO)
) (
    input  logic [T_DATA_RATIO-1:0] rem_keep_i,
    input  logic [T_DATA_WIDTH-1:0] hold_data_i [T_DATA_RATIO],
    output logic [IDX_W-1:0]        idx_o,
    output logic [T_DATA_WIDTH-1:0] lane_data_o,
    output logic                    onehot_o
);

    logic [MAX_RATIO-1:0] keep_ext;

    // Widen the mask to the helper width, then select the lane
    always_comb begin
        keep_ext    = MAX_RATIO'(rem_keep_i);
        idx_o       = IDX_W'(first_set(keep_ext));
        onehot_o    = is_onehot(keep_ext);
        lane_data_o = hold_data_i[idx_o];
    end

endmodule

// File: rtl/stream_downsize.sv
// Wide-to-narrow stream converter: accepts one wide beat of T_DATA_RATIO lanes with
// a keep mask and replays the kept lanes as narrow beats in ascending lane order.
// Optional feature macro: STREAM_DOWNSIZE_ERR_EN adds a sticky err_o that flags
// accepted beats carrying an all-zero keep mask.
module stream_downsize
    import stream_downsize_pkg::*;
#(
    parameter int unsigned T_DATA_WIDTH = 1,
    parameter int unsigned T_DATA_RATIO = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [T_DATA_WIDTH-1:0] s_data_i [T_DATA_RATIO],
    input  logic [T_DATA_RATIO-1:0] s_keep_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i
`ifdef STREAM_DOWNSIZE_ERR_EN
    ,
    output logic                    err_o
`endif
);

    localparam int unsigned IDX_W = $clog2(T_DATA_RATIO);

    state_e                  state_q;
    logic [T_DATA_WIDTH-1:0] hold_data_q [T_DATA_RATIO];
    logic [T_DATA_RATIO-1:0] rem_keep_q;
    logic                    hold_last_q;

    logic [IDX_W-1:0]        pick_idx;
    logic [T_DATA_WIDTH-1:0] pick_data;
    logic                    pick_onehot;

    logic                    s_accept;
    logic                    m_handshake;
    logic                    keep_nonzero;
    logic [T_DATA_RATIO-1:0] lane_bit;

    stream_lane_pick #(
        .T_DATA_WIDTH (T_DATA_WIDTH),
        .T_DATA_RATIO (T_DATA_RATIO)
    ) u_pick (
        .rem_keep_i  (rem_keep_q),
        .hold_data_i (hold_data_q),
        .idx_o       (pick_idx),
        .lane_data_o (pick_data),
        .onehot_o    (pick_onehot)
    );

    // Handshakes and outputs; m_* depend only on registered state
    always_comb begin
        m_valid_o    = (state_q == SEND);
        m_data_o     = m_valid_o ? pick_data : '0;
        m_last_o     = m_valid_o && hold_last_q && pick_onehot;
        // New wide beat only when idle or while the final pending lane leaves
        s_ready_o    = !rst_i && ((state_q == IDLE) || (m_ready_i && pick_onehot));
        s_accept     = s_valid_i && s_ready_o;
        m_handshake  = m_valid_o && m_ready_i;
        keep_nonzero = (s_keep_i != '0);
        lane_bit     = T_DATA_RATIO'(1) << pick_idx;
    end

    // FSM and held beat: load on accept, retire one lane per narrow handshake
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            hold_data_q <= '{default: '0};
            rem_keep_q  <= '0;
            hold_last_q <= 1'b0;
        end else if (s_accept && keep_nonzero) begin
            state_q     <= SEND;
            hold_data_q <= s_data_i;
            rem_keep_q  <= s_keep_i;
            hold_last_q <= s_last_i;
        end else if (m_handshake) begin
            rem_keep_q <= rem_keep_q & ~lane_bit;
            if (pick_onehot) begin
                state_q <= IDLE;
            end
        end
    end

`ifdef STREAM_DOWNSIZE_ERR_EN
    logic err_q;

    // Sticky flag for a zero-keep beat; only reset clears it
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (s_accept && !keep_nonzero) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`endif

endmodule
